// File: rtl/hilo_md_unit_pkg.sv
// Shared multiply/divide definitions: operation encoding, FSM states and default latencies.
package md_pkg;

  localparam int unsigned MD_OP_W        = 4;
  localparam int unsigned MD_DATA_W      = 32;
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_multi_cycle(md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hilo_md_unit_if.sv
// Execute-stage port bundle between the pipeline and the HI/LO multiply/divide unit.
interface hilo_md_unit_if;
  import md_pkg::*;

  md_op_t                 E_md_op;
  logic [MD_DATA_W-1:0]   E_rs;
  logic [MD_DATA_W-1:0]   E_rt;
  logic                   start;
  logic                   busy;
  logic [MD_DATA_W-1:0]   E_md_rdata;
  logic [MD_DATA_W-1:0]   hi;
  logic [MD_DATA_W-1:0]   lo;

  modport master (
    output E_md_op, E_rs, E_rt,
    input  start, busy, E_md_rdata, hi, lo
  );

  modport slave (
    input  E_md_op, E_rs, E_rt,
    output start, busy, E_md_rdata, hi, lo
  );

endinterface

// File: rtl/hilo_md_unit_compute.sv
// Combinational 64-bit product and quotient/remainder; a zero divisor returns the current HI/LO.
module md_compute
  import md_pkg::*;
(
  input  md_op_t               op_i,
  input  logic [MD_DATA_W-1:0] rs_i,
  input  logic [MD_DATA_W-1:0] rt_i,
  input  logic [MD_DATA_W-1:0] hi_i,
  input  logic [MD_DATA_W-1:0] lo_i,
  output logic [MD_DATA_W-1:0] hi_c_o,
  output logic [MD_DATA_W-1:0] lo_c_o
);

  localparam int unsigned PW = 2 * MD_DATA_W;

  logic [PW-1:0]        prod_s;
  logic [PW-1:0]        prod_u;
  logic [MD_DATA_W-1:0] div_u;
  logic [MD_DATA_W-1:0] q_u;
  logic [MD_DATA_W-1:0] r_u;
  logic [MD_DATA_W-1:0] mag_rs;
  logic [MD_DATA_W-1:0] mag_rt;
  logic [MD_DATA_W-1:0] q_mag;
  logic [MD_DATA_W-1:0] r_mag;
  logic                 div_zero;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{MD_DATA_W{rs_i[MD_DATA_W-1]}}, rs_i} * {{MD_DATA_W{rt_i[MD_DATA_W-1]}}, rt_i};
  assign prod_u = {{MD_DATA_W{1'b0}}, rs_i} * {{MD_DATA_W{1'b0}}, rt_i};

  // Divisor forced to 1 on zero so the divider never sees x; the result is discarded anyway.
  assign div_zero = (rt_i == '0);
  assign div_u    = div_zero ? MD_DATA_W'(1) : rt_i;
  assign q_u      = rs_i / div_u;
  assign r_u      = rs_i % div_u;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps to 0x80000000 deterministically.
  assign mag_rs = rs_i[MD_DATA_W-1] ? MD_DATA_W'(-rs_i) : rs_i;
  assign mag_rt = rt_i[MD_DATA_W-1] ? MD_DATA_W'(-rt_i) : rt_i;
  assign q_mag  = mag_rs / (div_zero ? MD_DATA_W'(1) : mag_rt);
  assign r_mag  = mag_rs % (div_zero ? MD_DATA_W'(1) : mag_rt);

  always_comb begin
    hi_c_o = hi_i;
    lo_c_o = lo_i;
    case (op_i)
      MD_MULT:  {hi_c_o, lo_c_o} = prod_s;
      MD_MULTU: {hi_c_o, lo_c_o} = prod_u;
      MD_DIV: begin
        if (!div_zero) begin
          lo_c_o = (rs_i[MD_DATA_W-1] ^ rt_i[MD_DATA_W-1]) ? MD_DATA_W'(-q_mag) : q_mag;
          hi_c_o = rs_i[MD_DATA_W-1] ? MD_DATA_W'(-r_mag) : r_mag;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          lo_c_o = q_u;
          hi_c_o = r_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_md_unit.sv
// Multiply/divide sequencer owning HI/LO: accepts one op when idle, commits multi-cycle results on countdown expiry.
module hilo_md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  hilo_md_unit_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  md_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic [MD_DATA_W-1:0] hi_q;
  logic [MD_DATA_W-1:0] lo_q;
  logic [MD_DATA_W-1:0] hi_tmp_q;
  logic [MD_DATA_W-1:0] lo_tmp_q;
  logic [MD_DATA_W-1:0] hi_res_d;
  logic [MD_DATA_W-1:0] lo_res_d;
  logic [CNT_W-1:0]     cnt_load_d;
  logic                 start_c;
  logic                 is_mult_c;

  md_compute u_compute (
    .op_i   (bus.E_md_op),
    .rs_i   (bus.E_rs),
    .rt_i   (bus.E_rt),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .hi_c_o (hi_res_d),
    .lo_c_o (lo_res_d)
  );

  assign start_c    = (state_q == ST_IDLE) && is_multi_cycle(bus.E_md_op);
  assign is_mult_c  = (bus.E_md_op == MD_MULT) || (bus.E_md_op == MD_MULTU);
  assign cnt_load_d = is_mult_c ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  // Sequencer: IDLE accepts and captures the result, RUN counts down and commits at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            hi_tmp_q <= hi_res_d;
            lo_tmp_q <= lo_res_d;
            cnt_q    <= cnt_load_d;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else if (bus.E_md_op == MD_MTHI) begin
            hi_q <= bus.E_rs;
          end else if (bus.E_md_op == MD_MTLO) begin
            lo_q <= bus.E_rs;
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hi_tmp_q;
            lo_q    <= lo_tmp_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.E_md_rdata = '0;
    case (bus.E_md_op)
      MD_MFHI: bus.E_md_rdata = hi_q;
      MD_MFLO: bus.E_md_rdata = lo_q;
      default: ;
    endcase
  end

  assign bus.start = start_c;
  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: vector table of ops with hand-computed HI/LO and busy lengths, plus reset/illegal-issue sequences.
module tb_hilo_md_unit;
  import md_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hilo_md_unit_if bus ();

  hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    md_op_t      op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    int          exp_cyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // start and busy must never be high together.
  always @(negedge clk) begin
    if (rst_n) chk("start_busy_excl", 32'(bus.start & bus.busy), 32'd0);
  end

  // Issue one op in the current (mid-cycle) slot, measure busy, then check HI/LO and MFHI/MFLO.
  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    bus.E_md_op = v.op;
    bus.E_rs    = v.rs;
    bus.E_rt    = v.rt;
    #1;
    chk($sformatf("v%0d_start", idx), 32'(bus.start), 32'(v.exp_start));
    @(posedge clk);
    #1;
    bus.E_md_op = MD_NONE;
    bus.E_rs    = '0;
    bus.E_rt    = '0;
    cnt = 0;
    @(negedge clk);
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_busy_cycles", idx), 32'(cnt), 32'(v.exp_cyc));
    chk($sformatf("v%0d_hi", idx), bus.hi, v.exp_hi);
    chk($sformatf("v%0d_lo", idx), bus.lo, v.exp_lo);
    bus.E_md_op = MD_MFHI;
    #1;
    chk($sformatf("v%0d_mfhi", idx), bus.E_md_rdata, v.exp_hi);
    bus.E_md_op = MD_MFLO;
    #1;
    chk($sformatf("v%0d_mflo", idx), bus.E_md_rdata, v.exp_lo);
    bus.E_md_op = MD_NONE;
    #1;
    chk($sformatf("v%0d_rdata_none", idx), bus.E_md_rdata, 32'd0);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;

    //         op        rs            rt            start cyc hi            lo
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'd100,      32'd7,        1'b1, 10, 32'd2,        32'd14};
    vecs[4]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 1'b1, 10, 32'd1,        32'hFFFFFFFD};
    vecs[5]  = '{MD_MULT,  32'h80000000, 32'h80000000, 1'b1, 5,  32'h40000000, 32'h00000000};
    vecs[6]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
    vecs[7]  = '{MD_MTHI,  32'h00001234, 32'h0,        1'b0, 0,  32'h00001234, 32'h80000000};
    vecs[8]  = '{MD_MTLO,  32'h00005678, 32'h0,        1'b0, 0,  32'h00001234, 32'h00005678};
    vecs[9]  = '{MD_DIVU,  32'hDEADBEEF, 32'h0,        1'b1, 10, 32'h00001234, 32'h00005678};
    vecs[10] = '{MD_DIV,   32'hFFFFFFF9, 32'h0,        1'b1, 10, 32'h00001234, 32'h00005678};
    vecs[11] = '{MD_MTHI,  32'hCAFEBABE, 32'h0,        1'b0, 0,  32'hCAFEBABE, 32'h00005678};

    rst_n       = 1'b0;
    bus.E_md_op = MD_NONE;
    bus.E_rs    = '0;
    bus.E_rt    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_rdata", bus.E_md_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Rows run back to back: each new op is issued in the first cycle busy is low.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // MTHI then MFHI in the very next cycle.
    @(negedge clk);
    bus.E_md_op = MD_MTHI;
    bus.E_rs    = 32'h0BADF00D;
    @(posedge clk);
    #1;
    bus.E_md_op = MD_MFHI;
    bus.E_rs    = '0;
    #1;
    chk("mthi_mfhi_next", bus.E_md_rdata, 32'h0BADF00D);
    chk("mthi_no_busy", 32'(bus.busy), 32'd0);
    bus.E_md_op = MD_NONE;

    // Illegal issue: MULT and MTHI presented during busy are ignored.
    @(negedge clk);
    bus.E_md_op = MD_MULT;
    bus.E_rs    = 32'd3;
    bus.E_rt    = 32'd4;
    @(posedge clk);
    #1;
    bus.E_md_op = MD_NONE;
    @(negedge clk);
    cnt = 1;
    bus.E_md_op = MD_MULT;
    bus.E_rs    = 32'd5;
    bus.E_rt    = 32'd5;
    #1;
    chk("illegal_start", 32'(bus.start), 32'd0);
    @(negedge clk);
    cnt++;
    bus.E_md_op = MD_MTHI;
    bus.E_rs    = 32'hDEAD0000;
    @(negedge clk);
    cnt++;
    bus.E_md_op = MD_NONE;
    chk("illegal_mthi_hi", bus.hi, 32'h0BADF00D);
    while (bus.busy && cnt < 40) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("illegal_busy_cycles", 32'(cnt), 32'd5);
    chk("illegal_hi", bus.hi, 32'd0);
    chk("illegal_lo", bus.lo, 32'd12);

    // Reset during cycle 4 of a DIV aborts it with HI/LO cleared.
    bus.E_md_op = MD_DIVU;
    bus.E_rs    = 32'd100;
    bus.E_rt    = 32'd7;
    @(posedge clk);
    #1;
    bus.E_md_op = MD_NONE;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_hi", bus.hi, 32'd0);
    chk("post_rst_lo", bus.lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Multiply/divide sequencer and HI/LO register owner for the five-stage pipeline. It sits in the Execute stage beside the ALU and accepts one mult/div/move operation per cycle when idle. Multi-cycle operations run against a countdown counter, and the block commits their results to HI/LO on completion. Its `start` and `busy` outputs feed the hazard unit, which stalls any HI/LO-touching instruction in Decode while either is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `E_md_op`  in  4: operation code from the package; `MD_NONE` = no operation.
- `E_rs`  in  32: first operand (dividend / multiplicand / mthi, mtlo source).
- `E_rt`  in  32: second operand (divisor / multiplier).
- `start`  out  1: combinational; high in the cycle a mult/div is accepted.
- `busy`  out  1: registered; high while a mult/div is in flight.
- `E_md_rdata`  out  32: combinational; HI for `MD_MFHI`, LO for `MD_MFLO`, 0 otherwise.
- `hi`, `lo`  out  32 each: architectural HI/LO registers.

## Operation
- States: IDLE, RUN.
- In IDLE:
  - `start = 1` iff `E_md_op` is MULT, MULTU, DIV or DIVU.
  - On that edge, compute the full result into `hi_tmp`/`lo_tmp`, load the counter with the op's cycle count, and go to RUN.
- In RUN:
  - Decrement the counter each edge.
  - When the counter reaches 1, write `hi_tmp`/`lo_tmp` to `hi`/`lo`, clear the counter and go to IDLE on the same edge.
- Results:
  - MULT: signed 64-bit product; `{hi,lo}` = product.
  - MULTU: unsigned 64-bit product; `{hi,lo}` = product.
  - DIV: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0: `hi`/`lo` keep their prior values, but `busy` still lasts `DIV_CYCLES`.
- MTHI/MTLO: write `E_rs` to `hi`/`lo` at the next edge when IDLE. No busy period, and `start` stays 0.
- MFHI/MFLO: pure combinational reads of the current `hi`/`lo`. No state change.
- Any op presented while `busy = 1` is ignored: no write, no restart. The hazard unit guarantees this never happens; the bench asserts it.
- Counter width is `$clog2(DIV_CYCLES+1)`. Both parameters must be at least 1.

## Timing
- Reset values: `busy = 0`, `hi = 0`, `lo = 0`, counter = 0, state IDLE, temporaries 0.
- `start` and `E_md_rdata` follow their inputs combinationally, so they also read 0 during reset.
- A mult accepted in cycle t:
  - `busy` is high in cycles t+1 through t+MULT_CYCLES.
  - The new `hi`/`lo` is visible from cycle t+MULT_CYCLES+1, in the same cycle `busy` falls.
- Div follows the same pattern using `DIV_CYCLES`.
- `start` and `busy` are never high in the same cycle.
- The next mult/div may be accepted in the first cycle `busy` is low (back-to-back with no gap).
- MTHI in cycle t makes `hi` visible at t+1. MFHI in cycle t+1 returns the new value.
- Reset asserted mid-RUN aborts the operation. HI/LO are cleared, not committed.

## Structure
- Shared package `md_pkg` holds the `md_op_t` 4-bit enum: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- `md_pkg` also holds the default cycle-count constants, which the decoder and hazard unit reuse to derive `HILO_operation`.
- One sub-module, `md_compute`: purely combinational 64-bit signed/unsigned product and quotient/remainder, including the divide-by-zero hold. It is instantiated once.
- The FSM, counter and HI/LO registers live in the top module.

## Test plan
- Signed multiply: reset, then MULT with rs=0xFFFFFFFF, rt=2.
  - `start` is high 1 cycle and `busy` exactly 5 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned multiply: MULTU with rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- Signed divide: DIV with rs=0xFFFFFFF9 (-7), rt=2.
  - `busy` lasts 10 cycles.
  - Afterwards lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: MTHI 0x1234, then MTLO 0x5678, then DIVU with rt=0.
  - `busy` lasts 10 cycles.
  - hi=0x1234 and lo=0x5678 remain unchanged.
- Move then read: MTHI with rs=0xCAFEBABE, then MFHI on the next cycle → `E_md_rdata` = 0xCAFEBABE, `busy` stays 0.
- Reset mid-operation and illegal issue:
  - Pull `rst_n` low during cycle 4 of a DIV: `busy`, `hi` and `lo` read 0 immediately.
  - A MULT issued during `busy` changes nothing.
